// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: register offsets,
// control bit positions and the CPU handshake state encoding.
package int_ctrl_pkg;

   localparam logic [1:0] REG_MASK = 2'd0;
   localparam logic [1:0] REG_PEND = 2'd1;
   localparam logic [1:0] REG_MODE = 2'd2;
   localparam logic [1:0] REG_VEC  = 2'd3;

   localparam int GE_BIT    = 31;
   localparam int VALID_BIT = 31;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ASSERT = 2'd1,
      INSERV = 2'd2
   } state_t;

endpackage

// File: rtl/int_sync_edge.sv
// Two-flop synchroniser for every raw request plus a delay stage that
// exposes synchronised rising edges.
module int_sync_edge #(
   parameter int N = 6
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] d,
   output logic [N-1:0] s2,
   output logic [N-1:0] rise
);

   logic [N-1:0] s1, s3;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= '0;
         s2 <= '0;
         s3 <= '0;
      end else begin
         s1 <= d;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign rise = s2 & ~s3;

endmodule

// File: rtl/int_ctrl.sv
// Programmable interrupt controller: latches synchronised requests, applies
// mask/mode, picks the lowest-index active source and runs the CPU handshake.
module int_ctrl
   import int_ctrl_pkg::*;
#(
   parameter int N_SRC = 6,
   parameter int ID_W  = 3
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [N_SRC-1:0] src,
   input  logic [1:0]       addr,
   input  logic             we,
   input  logic [31:0]      din,
   output logic [31:0]      dout,
   input  logic             ack,
   output logic             irq,
   output logic [ID_W-1:0]  irq_id
);

   logic [N_SRC-1:0] s2, rise;
   logic [N_SRC-1:0] mask_q, mode_q, pend_q, active;
   logic             ge_q;
   logic [ID_W-1:0]  sel, id_n;
   logic             irq_n;
   state_t           state_q, state_n;
   logic             wr_mask, wr_pend, wr_mode, eoi, ack_clr;
   logic             unused_din;

   // Only the low N_SRC bits and the GE bit of the write bus are meaningful.
   assign unused_din = ^din;

   int_sync_edge #(.N(N_SRC)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d     (src),
      .s2    (s2),
      .rise  (rise)
   );

   assign wr_mask = we && (addr == REG_MASK);
   assign wr_pend = we && (addr == REG_PEND);
   assign wr_mode = we && (addr == REG_MODE);
   assign eoi     = we && (addr == REG_VEC);
   assign ack_clr = ack && (state_q == ASSERT);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         mask_q <= '0;
         ge_q   <= 1'b0;
         mode_q <= '0;
      end else begin
         if (wr_mask) begin
            mask_q <= din[N_SRC-1:0];
            ge_q   <= din[GE_BIT];
         end
         if (wr_mode) mode_q <= din[N_SRC-1:0];
      end
   end

   // Per-source pending bit; a new edge beats a simultaneous clear.
   for (genvar i = 0; i < N_SRC; i++) begin : g_pend
      logic clr;
      assign clr = (wr_pend && din[i]) || (ack_clr && (irq_id == ID_W'(i)));

      always_ff @(posedge clk or negedge reset) begin
         if (!reset)
            pend_q[i] <= 1'b0;
         else if (!mode_q[i])
            pend_q[i] <= (wr_mode && din[i]) ? 1'b0 : s2[i];
         else
            pend_q[i] <= rise[i] | (pend_q[i] & ~clr);
      end
   end

   assign active = pend_q & mask_q & {N_SRC{ge_q}};

   always_comb begin
      sel = '0;
      for (int i = N_SRC - 1; i >= 0; i--)
         if (active[i]) sel = ID_W'(i);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= IDLE;
         irq     <= 1'b0;
         irq_id  <= '0;
      end else begin
         state_q <= state_n;
         irq     <= irq_n;
         irq_id  <= id_n;
      end
   end

   always_comb begin
      state_n = state_q;
      irq_n   = irq;
      id_n    = irq_id;
      case (state_q)
         IDLE: begin
            if (active != '0) begin
               state_n = ASSERT;
               irq_n   = 1'b1;
               id_n    = sel;
            end
         end
         ASSERT: begin
            if (ack) begin
               state_n = INSERV;
               irq_n   = 1'b0;
            end else if (active == '0) begin
               state_n = IDLE;
               irq_n   = 1'b0;
            end else begin
               id_n = sel;
            end
         end
         INSERV: begin
            irq_n = 1'b0;
            if (eoi) state_n = IDLE;
         end
         default: begin
            state_n = IDLE;
            irq_n   = 1'b0;
         end
      endcase
   end

   always_comb begin
      dout = '0;
      case (addr)
         REG_MASK: begin
            dout[N_SRC-1:0] = mask_q;
            dout[GE_BIT]    = ge_q;
         end
         REG_PEND: dout[N_SRC-1:0] = pend_q & mask_q;
         REG_MODE: dout[N_SRC-1:0] = mode_q;
         default: begin
            dout[ID_W-1:0]  = irq_id;
            dout[VALID_BIT] = (state_q != IDLE);
         end
      endcase
   end

endmodule

// File: tb/tb_int_ctrl.sv
// Directed bench for int_ctrl: handshake latency, priority retargeting,
// masking, edge/level modes and asynchronous reset.
module tb_int_ctrl;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [5:0]  src = '0;
   logic [1:0]  addr = '0;
   logic        we = 1'b0;
   logic [31:0] din = '0;
   logic [31:0] dout;
   logic        ack = 1'b0;
   logic        irq;
   logic [2:0]  irq_id;
   logic [31:0] rv;

   int n_chk = 0;
   int n_fail = 0;

   int_ctrl #(.N_SRC(6), .ID_W(3)) dut (
      .clk    (clk),
      .reset  (reset),
      .src    (src),
      .addr   (addr),
      .we     (we),
      .din    (din),
      .dout   (dout),
      .ack    (ack),
      .irq    (irq),
      .irq_id (irq_id)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      addr = a;
      din  = d;
      we   = 1'b1;
      @(negedge clk);
      we   = 1'b0;
      din  = '0;
   endtask

   task automatic rd(input logic [1:0] a, output logic [31:0] d);
      addr = a;
      #1;
      d = dout;
   endtask

   task automatic ack_pulse();
      ack = 1'b1;
      @(negedge clk);
      ack = 1'b0;
   endtask

   initial begin
      // reset, all sources high, nothing configured
      src = 6'h3F;
      cyc(3);
      reset = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("noconf_irq", {31'b0, irq}, 32'h0);
      end
      for (int a = 0; a < 4; a++) begin
         rd(2'(a), rv);
         chk("reset_reg", rv, 32'h0);
      end
      src = 6'h00;
      cyc(4);

      // level source 0: latency, ack, EOI re-request
      wr(2'd2, 32'h0);
      wr(2'd0, 32'h8000_0001);
      src = 6'h01;
      cyc(3);
      chk("lvl_irq_k2", {31'b0, irq}, 32'h0);
      cyc(1);
      chk("lvl_irq_k3", {31'b0, irq}, 32'h1);
      chk("lvl_id", {29'b0, irq_id}, 32'h0);
      ack_pulse();
      chk("lvl_ack_irq", {31'b0, irq}, 32'h0);
      rd(2'd3, rv);
      chk("lvl_vec", rv, 32'h8000_0000);
      wr(2'd3, 32'h0);
      chk("lvl_eoi_irq", {31'b0, irq}, 32'h0);
      rd(2'd3, rv);
      chk("lvl_eoi_vec", rv, 32'h0);
      cyc(1);
      chk("lvl_rereq", {31'b0, irq}, 32'h1);
      src = 6'h00;
      cyc(4);
      chk("lvl_withdraw", {31'b0, irq}, 32'h0);

      // single-cycle edge pulse on source 2
      wr(2'd2, 32'h04);
      wr(2'd0, 32'h8000_0004);
      src = 6'h04;
      cyc(1);
      src = 6'h00;
      cyc(3);
      chk("edge_irq", {31'b0, irq}, 32'h1);
      chk("edge_id", {29'b0, irq_id}, 32'h2);
      rd(2'd1, rv);
      chk("edge_pend", rv, 32'h04);
      ack_pulse();
      chk("edge_ack_irq", {31'b0, irq}, 32'h0);
      rd(2'd1, rv);
      chk("edge_ack_pend", rv, 32'h0);
      wr(2'd3, 32'h0);
      cyc(3);
      chk("edge_no_rereq", {31'b0, irq}, 32'h0);
      rd(2'd3, rv);
      chk("edge_valid", {31'b0, rv[31]}, 32'h0);

      // priority retarget before ack, then lower source served after EOI
      wr(2'd0, 32'h8000_0003);
      wr(2'd2, 32'h03);
      src = 6'h02;
      cyc(2);
      src = 6'h03;
      cyc(2);
      chk("pri_irq1", {31'b0, irq}, 32'h1);
      chk("pri_id1", {29'b0, irq_id}, 32'h1);
      cyc(2);
      chk("pri_irq0", {31'b0, irq}, 32'h1);
      chk("pri_id0", {29'b0, irq_id}, 32'h0);
      ack_pulse();
      chk("pri_ack_irq", {31'b0, irq}, 32'h0);
      wr(2'd3, 32'h0);
      chk("pri_eoi_irq", {31'b0, irq}, 32'h0);
      cyc(1);
      chk("pri_next_irq", {31'b0, irq}, 32'h1);
      chk("pri_next_id", {29'b0, irq_id}, 32'h1);
      ack_pulse();
      wr(2'd3, 32'h0);
      src = 6'h00;
      cyc(3);
      chk("pri_done", {31'b0, irq}, 32'h0);

      // global enable withdrawal while asserted; EOI ignored in ASSERT
      wr(2'd2, 32'h0);
      wr(2'd0, 32'h8000_0008);
      src = 6'h08;
      cyc(4);
      chk("ge_irq", {31'b0, irq}, 32'h1);
      chk("ge_id", {29'b0, irq_id}, 32'h3);
      wr(2'd3, 32'h0);
      chk("eoi_in_assert", {31'b0, irq}, 32'h1);
      rd(2'd3, rv);
      chk("ge_vec", rv, 32'h8000_0003);
      wr(2'd0, 32'h0000_0008);
      chk("ge_off_edge", {31'b0, irq}, 32'h1);
      cyc(1);
      chk("ge_off_irq", {31'b0, irq}, 32'h0);
      rd(2'd3, rv);
      chk("ge_off_valid", {31'b0, rv[31]}, 32'h0);
      wr(2'd0, 32'h8000_0008);
      chk("ge_on_edge", {31'b0, irq}, 32'h0);
      cyc(1);
      chk("ge_on_irq", {31'b0, irq}, 32'h1);

      // asynchronous reset while in service with an edge re-fire pending
      src = 6'h00;
      cyc(4);
      chk("pre_rst_idle", {31'b0, irq}, 32'h0);
      wr(2'd2, 32'h08);
      src = 6'h08;
      cyc(4);
      chk("rst_irq", {31'b0, irq}, 32'h1);
      ack_pulse();
      chk("rst_ack_irq", {31'b0, irq}, 32'h0);
      src = 6'h00;
      cyc(2);
      src = 6'h08;
      cyc(4);
      rd(2'd1, rv);
      chk("inserv_pend", rv, 32'h08);
      chk("inserv_irq", {31'b0, irq}, 32'h0);
      #2;
      reset = 1'b0;
      #1;
      chk("rst_async_irq", {31'b0, irq}, 32'h0);
      rd(2'd1, rv);
      chk("rst_pend", rv, 32'h0);
      rd(2'd3, rv);
      chk("rst_vec", rv, 32'h0);
      cyc(2);
      reset = 1'b1;
      cyc(10);
      chk("post_rst_irq", {31'b0, irq}, 32'h0);

      // write-1-clear of an edge pending bit
      wr(2'd2, 32'h08);
      wr(2'd0, 32'h08);
      src = 6'h00;
      cyc(3);
      src = 6'h08;
      cyc(4);
      rd(2'd1, rv);
      chk("w1c_set", rv, 32'h08);
      wr(2'd1, 32'h08);
      rd(2'd1, rv);
      chk("w1c_clr", rv, 32'h0);
      chk("w1c_irq", {31'b0, irq}, 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
Programmable interrupt controller between the system interrupt sources (TC0 IRQ, TC1 IRQ, external interrupt, spares) and the CPU's interrupt input. It synchronises and latches requests, applies per-source mask and level/edge mode, and selects the highest-priority pending source. It drives a single IRQ line to the CPU through an assert/ack/EOI handshake. Registers are accessed as a bridge device through word-addressed read/write, in the same way as the TC devices.

Parameters:
N_SRC, 6, number of interrupt sources (maximum 31).
ID_W, 3, width of the source index (must be at least clog2(N_SRC)).

Ports:
clk  input  1  system clock
reset  input  1  asynchronous, active-low reset
src  input  N_SRC  raw interrupt requests, active-high; src[0] has the highest priority
addr  input  2  register word select, driven from bridge DEVAddr[3:2]
we  input  1  register write enable, driven from the bridge
din  input  32  write data
dout  output  32  read data, combinational from addr
ack  input  1  one-cycle pulse from the CPU when it takes the interrupt exception
irq  output  1  interrupt request to the CPU, registered
irq_id  output  ID_W  index of the source being signalled or serviced, registered

Behaviour:
Register map:
- addr 0, MASK: bits[N_SRC-1:0] enable each source; bit31 GE is the global enable. Read/write.
- addr 1, PEND: read returns effective pending bits. Writing 1 clears an edge-mode bit; writes to level-mode bits are ignored.
- addr 2, MODE: bit i = 1 selects edge mode, 0 selects level mode. Read/write.
- addr 3, VEC: read returns {valid at bit31, 0s, irq_id}; valid = (state != IDLE). Any write is an EOI. Reads have no side effects.

Reset (reset = 0, asynchronous): all synchroniser and edge flops, MASK, GE, MODE, PEND and irq_id are 0; state = IDLE; irq = 0.

Input path:
- Two-flop synchroniser (s1, s2) on every src bit, plus a delay flop s3 for edge detection.
- Edge mode: pend[i] sets on s2 & ~s3. If a set and a write-1-clear hit the same edge, the set wins.
- Level mode: pend[i] = s2[i] every cycle.
- active = pend & MASK & {N_SRC{GE}}. sel = lowest index set in active.

Latency: src rises before edge k → s2 at k+1 → pend at k+2 → irq = 1 at k+3.

FSM states are IDLE, ASSERT and INSERV; all transitions happen on the clock edge.
- IDLE: if active != 0 → ASSERT, irq <= 1, irq_id <= sel.
- ASSERT:
  - ack → INSERV, irq <= 0, and clear pend[irq_id] if it is edge mode.
  - If ack is absent and active == 0 (masked, GE cleared or request withdrawn) → IDLE, irq <= 0.
  - Otherwise irq_id <= sel each cycle, so a higher-priority arrival re-targets before ack.
- INSERV: irq held at 0 and irq_id held, with no nesting. EOI → IDLE. If active != 0 on that same edge, IDLE re-asserts on the next edge (one idle cycle minimum).

Boundary rules:
- ack in IDLE or INSERV is ignored.
- EOI in IDLE or ASSERT is ignored.
- A level source still high after EOI re-requests.
- An edge source that re-fires while INSERV stays pending and is served after EOI.
- Changing MODE from edge to level makes pend follow s2 from the next edge. Changing level to edge starts with pend = 0 for that bit.
- Register writes take effect at the clock edge; dout reflects the new value from the next cycle.
- Reset asserted mid-handshake returns everything to reset values immediately; irq drops asynchronously.

Decomposition:
- Package int_ctrl_pkg holds:
  - register offsets REG_MASK = 0, REG_PEND = 1, REG_MODE = 2, REG_VEC = 3;
  - GE_BIT = 31 and VALID_BIT = 31;
  - the state encoding (IDLE, ASSERT, INSERV).
- One sub-module, int_sync_edge: the N_SRC-wide synchroniser plus edge detector, with outputs s2 and rise = s2 & ~s3.
- Register file, priority encoder and FSM stay in int_ctrl.

Test Plan:
- Reset with src = 6'h3F and no configuration → irq stays 0 for 20 cycles; reads of all registers return 0.
- Set MASK = 0x8000_0001, MODE = 0, then raise src[0] before edge k → irq = 1 and irq_id = 0 at k+3. Pulse ack → irq = 0, VEC = 0x8000_0000. Write VEC → irq = 1 again two edges later while src[0] is still high.
- Set MODE = 0x04, MASK = 0x8000_0004, pulse src[2] for one cycle → PEND = 0x04 and irq_id = 2. After ack, PEND = 0 and irq = 0. EOI → state IDLE with no re-request.
- Set MASK = 0x8000_0003, MODE = 0x03, raise src[1] and, two cycles later, src[0], with no ack → irq_id moves 1 → 0 with irq held at 1. ack + EOI → src1 is served next (irq_id = 1).
- Pending src[3] in ASSERT, then write MASK = 0x0000_0008 (GE = 0) → irq = 0 on the next edge and VEC valid = 0. Restore GE → irq re-asserts.
- Drop reset to 0 while in INSERV with an edge bit pending → irq = 0 and PEND = 0 immediately. After release, no request occurs until a new edge.
